frogger_game_ctrl: RTL

- Top-level game sequencer for the 16x16 LED-matrix Frogger build.
- Runs the game flow (idle, play, dying, game over, win) and owns lives and score.
- Drives reset/hit strobes into the lane, frog and sticky overlay-row blocks.
- Arbitrates the display row scan between the playfield and the overlay rows (game-over/win banner).

---
 rtl/frogger_pkg.sv | 20 ++
 rtl/frogger_row_scan.sv | 52 +++++
 rtl/frogger_game_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and default sizing for the Frogger game controller slice.
package frogger_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    DYING = 3'd2,
    OVER  = 3'd3,
    WIN   = 3'd4
  } game_state_t;

  localparam int NROWS_DEF     = 16;
  localparam int LIVES_DEF     = 3;
  localparam int WIN_SCORE_DEF = 5;
  localparam int DIE_TICKS_DEF = 4;
  localparam int OVL_TOP_DEF   = 6;
  localparam int OVL_ROWS_DEF  = 4;
  localparam int ROW_W         = $clog2(NROWS_DEF);

endpackage

// File: rtl/frogger_row_scan.sv
// Free-running display row counter with the overlay-window source select.
module frogger_row_scan #(
  parameter int NROWS    = 16,
  parameter int OVL_TOP  = 6,
  parameter int OVL_ROWS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ovl_active_i,
  output logic [$clog2(NROWS)-1:0] row_sel_o,
  output logic                     src_sel_o
);

  localparam int RW = $clog2(NROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(NROWS - 1);
  localparam logic [RW:0]   WIN_LO   = (RW + 1)'(OVL_TOP);
  localparam logic [RW:0]   WIN_HI   = (RW + 1)'(OVL_TOP + OVL_ROWS - 1);

  logic [RW-1:0] row_q, row_d;
  logic          src_q, src_d;

  // Next row and its window decision are computed together so both registers describe the same row.
  always_comb begin
    row_d = row_q;
    src_d = 1'b0;
    if (row_q == ROW_LAST) begin
      row_d = '0;
    end else begin
      row_d = row_q + RW'(1);
    end
    if (ovl_active_i && ({1'b0, row_d} >= WIN_LO) && ({1'b0, row_d} <= WIN_HI)) begin
      src_d = 1'b1;
    end else begin
      src_d = 1'b0;
    end
  end

  // Scan registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      src_q <= 1'b0;
    end else begin
      row_q <= row_d;
      src_q <= src_d;
    end
  end

  assign row_sel_o = row_q;
  assign src_sel_o = src_q;

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: game-flow FSM, lives/score bookkeeping, strobes and display scan.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int NROWS     = NROWS_DEF,
  parameter int LIVES     = LIVES_DEF,
  parameter int WIN_SCORE = WIN_SCORE_DEF,
  parameter int DIE_TICKS = DIE_TICKS_DEF,
  parameter int OVL_TOP   = OVL_TOP_DEF,
  parameter int OVL_ROWS  = OVL_ROWS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tick,
  input  logic                     collision,
  input  logic                     goal,
  output logic                     play_en,
  output logic                     lane_reset,
  output logic                     frog_reset,
  output logic                     gg_hit,
  output logic                     win_hit,
  output logic                     ovl_clear,
  output logic                     blank,
  output logic [1:0]               lives,
  output logic [3:0]               score,
  output logic [$clog2(NROWS)-1:0] row_sel,
  output logic                     src_sel
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] SCORE_WIN  = 4'(WIN_SCORE);
  localparam logic [3:0] TIMER_INIT = 4'(DIE_TICKS);

  game_state_t state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  timer_q, timer_d;
  logic        start_q;
  logic        start_edge;
  logic        frog_d, gg_d, win_d, ovl_d;
  logic        play_en_q, lane_reset_q, blank_q;
  logic        frog_q, gg_q, win_q, ovl_q;
  logic        ovl_active;

  assign start_edge = start & ~start_q;

  // Game-flow next state, counters and strobe requests.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    timer_d = timer_q;
    frog_d  = 1'b0;
    gg_d    = 1'b0;
    win_d   = 1'b0;
    ovl_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
          score_d = 4'd0;
          frog_d  = 1'b1;
          ovl_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        // A car hit in the same cycle as a crossing costs the life; the crossing is lost.
        if (collision) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            timer_d = TIMER_INIT;
            state_d = DYING;
          end else begin
            lives_d = 2'd0;
            gg_d    = 1'b1;
            state_d = OVER;
          end
        end else if (goal) begin
          if ((score_q + 4'd1) == SCORE_WIN) begin
            score_d = score_q + 4'd1;
            win_d   = 1'b1;
            state_d = WIN;
          end else if (score_q < SCORE_WIN) begin
            score_d = score_q + 4'd1;
            frog_d  = 1'b1;
          end else begin
            score_d = score_q;
          end
        end else begin
          state_d = PLAY;
        end
      end
      DYING: begin
        if (tick) begin
          if (timer_q <= 4'd1) begin
            timer_d = 4'd0;
            frog_d  = 1'b1;
            state_d = PLAY;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end else begin
          timer_d = timer_q;
        end
      end
      OVER, WIN: begin
        if (start_edge) begin
          ovl_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ovl_active = (state_d == OVER) || (state_d == WIN);

  // State, counters and all outputs are registered off the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lives_q      <= LIVES_INIT;
      score_q      <= 4'd0;
      timer_q      <= 4'd0;
      start_q      <= 1'b0;
      play_en_q    <= 1'b0;
      lane_reset_q <= 1'b1;
      blank_q      <= 1'b0;
      frog_q       <= 1'b0;
      gg_q         <= 1'b0;
      win_q        <= 1'b0;
      ovl_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      timer_q      <= timer_d;
      start_q      <= start;
      play_en_q    <= (state_d == PLAY);
      lane_reset_q <= (state_d == IDLE);
      blank_q      <= (state_d == DYING) && timer_d[0];
      frog_q       <= frog_d;
      gg_q         <= gg_d;
      win_q        <= win_d;
      ovl_q        <= ovl_d;
    end
  end

  frogger_row_scan #(
    .NROWS    (NROWS),
    .OVL_TOP  (OVL_TOP),
    .OVL_ROWS (OVL_ROWS)
  ) u_row_scan (
    .clk          (clk),
    .reset        (reset),
    .ovl_active_i (ovl_active),
    .row_sel_o    (row_sel),
    .src_sel_o    (src_sel)
  );

  assign play_en    = play_en_q;
  assign lane_reset = lane_reset_q;
  assign blank      = blank_q;
  assign frog_reset = frog_q;
  assign gg_hit     = gg_q;
  assign win_hit    = win_q;
  assign ovl_clear  = ovl_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule
